// File: rtl/colors_to_bytes.sv
`default_nettype none
// ============================================================================
// Module      : colors_to_bytes
// Description : Packs a stream of 12-bit color words into a bytestream,
//               two colors -> three bytes, MSB first. A 24-bit buffer holds
//               left-aligned nibbles. Bytes leave from the top of the buffer
//               whenever the consumer requests one with readclk.
//               When an odd number of colors ends a stream (in_done), a fill
//               nibble completes the final byte.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               inclk    - color valid strobe (accepted only when rdy=1)
//               in       - color word
//               in_done  - qualifies inclk: last color of the stream
//               readclk  - consumer requests one byte this cycle
//               outclk   - byte valid on out this cycle
//               out      - output byte (top byte of the buffer)
//               rdy      - room for one more color
//               done     - pulses with outclk of the final byte of a stream
//               err      - sticky: a color arrived while rdy=0 and was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module colors_to_bytes #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inclk,
    input  logic [11:0] in,
    input  logic        in_done,
    input  logic        readclk,
    output logic        outclk,
    output logic [7:0]  out,
    output logic        rdy,
    output logic        done,
    output logic        err
);

    localparam int BYTE_LEN  = 8;
    localparam int COLOR_LEN = 12;
    localparam int BUF_LEN   = 2 * COLOR_LEN;

    // Nibble-granular storage; bits below the valid nibbles are always zero,
    // so new data can be OR-ed in at the current fill position.
    logic [BUF_LEN-1:0] r_buf;
    logic [2:0]         r_cnt;
    logic               r_last;
    logic               r_err;

    logic               w_outclk;
    logic               w_rdy;
    logic               w_accept;
    logic               w_done;
    logic               w_pad;
    logic [BUF_LEN-1:0] w_buf_s;
    logic [BUF_LEN-1:0] w_buf_n;
    logic [BUF_LEN-1:0] w_color_vec;
    logic [BUF_LEN-1:0] w_pad_vec;
    logic [2:0]         w_cnt_s;
    logic [2:0]         w_cnt_a;
    logic [2:0]         w_cnt_n;

    assign w_outclk = !rst && readclk && (r_cnt >= 3'd2);
    assign w_rdy    = !rst && (r_cnt <= 3'd3);
    assign w_accept = inclk && w_rdy;
    // Final byte of a stream is the one leaving while exactly two nibbles remain.
    assign w_done   = w_outclk && r_last && (r_cnt == 3'd2);

    // The color lands at the post-shift fill position; the fill nibble (if
    // any) goes directly behind it.
    assign w_color_vec = {in, {(BUF_LEN-COLOR_LEN){1'b0}}} >> {w_cnt_s, 2'b00};
    assign w_pad_vec   = {PAD_NIBBLE, {(BUF_LEN-4){1'b0}}} >> {w_cnt_a, 2'b00};

    always_comb begin
        w_buf_s = r_buf;
        w_cnt_s = r_cnt;
        if (w_outclk) begin
            w_buf_s = {r_buf[BUF_LEN-BYTE_LEN-1:0], {BYTE_LEN{1'b0}}};
            w_cnt_s = r_cnt - 3'd2;
        end

        w_cnt_a = w_cnt_s + 3'd3;
        // An odd nibble count after the last color leaves a half byte open.
        w_pad   = w_accept && in_done && w_cnt_a[0];

        w_buf_n = w_buf_s;
        w_cnt_n = w_cnt_s;
        if (w_accept) begin
            w_buf_n = w_buf_s | w_color_vec;
            w_cnt_n = w_cnt_a;
            if (w_pad) begin
                w_buf_n = w_buf_s | w_color_vec | w_pad_vec;
                w_cnt_n = w_cnt_a + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_cnt  <= 3'd0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_buf <= w_buf_n;
            r_cnt <= w_cnt_n;
            // A newly accepted final color outranks clearing the old marker,
            // so back-to-back streams keep their own end indication.
            if (w_accept && in_done) begin
                r_last <= 1'b1;
            end else if (w_done) begin
                r_last <= 1'b0;
            end
            if (inclk && !w_rdy) begin
                r_err <= 1'b1;
            end
        end
    end

    assign outclk = w_outclk;
    assign out    = r_buf[BUF_LEN-1 -: BYTE_LEN];
    assign rdy    = w_rdy;
    assign done   = w_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_colors_to_bytes.sv
`default_nettype none
// ============================================================================
// Module      : tb_colors_to_bytes
// Description : Self-checking bench for colors_to_bytes. A nibble-queue model
//               predicts outclk/out/rdy/done/err every cycle; directed tests
//               also check the logged byte sequences against literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_colors_to_bytes;

    localparam logic [3:0] PAD = 4'h5;

    logic        clk = 1'b0;
    logic        rst;
    logic        inclk;
    logic [11:0] color;
    logic        in_done;
    logic        readclk;
    logic        outclk;
    logic [7:0]  out_b;
    logic        rdy;
    logic        done;
    logic        err;

    colors_to_bytes #(.PAD_NIBBLE(PAD)) dut (
        .clk     (clk),
        .rst     (rst),
        .inclk   (inclk),
        .in      (color),
        .in_done (in_done),
        .readclk (readclk),
        .outclk  (outclk),
        .out     (out_b),
        .rdy     (rdy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of buffered nibbles ----------------
    logic [3:0] mq[$];
    bit         m_pend = 0;
    bit         m_err  = 0;
    bit         chk_en = 0;
    int         cyc    = 0;
    int         first_acc = -1;

    typedef struct {
        logic [7:0] b;
        logic       d;
        int         cyc;
    } ent_t;
    ent_t log_q[$];

    bit         e_oc, e_rdy, e_done;
    logic [7:0] e_out;

    function automatic logic [3:0] nib(input int i);
        return (mq.size() > i) ? mq[i] : 4'h0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        e_oc   = !rst && readclk && (mq.size() >= 2);
        e_rdy  = !rst && (mq.size() <= 3);
        e_done = e_oc && m_pend && (mq.size() == 2);
        e_out  = {nib(0), nib(1)};
        if (chk_en) begin
            chk("cyc_outclk", {31'd0, outclk}, {31'd0, e_oc});
            chk("cyc_rdy",    {31'd0, rdy},    {31'd0, e_rdy});
            chk("cyc_done",   {31'd0, done},   {31'd0, e_done});
            chk("cyc_err",    {31'd0, err},    {31'd0, m_err});
            chk("cyc_out",    {24'd0, out_b},  {24'd0, e_out});
            if (outclk === 1'b1) log_q.push_back('{out_b, done, cyc});
            if (inclk && e_rdy && first_acc < 0) first_acc = cyc;
        end
        // advance model to the state after the coming rising edge
        if (rst) begin
            mq.delete();
            m_pend = 0;
            m_err  = 0;
        end else begin
            if (e_oc) begin
                void'(mq.pop_front());
                void'(mq.pop_front());
                if (e_done) m_pend = 0;
            end
            if (inclk && e_rdy) begin
                mq.push_back(color[11:8]);
                mq.push_back(color[7:4]);
                mq.push_back(color[3:0]);
                if (in_done) begin
                    m_pend = 1;
                    if (mq.size() % 2 == 1) mq.push_back(PAD);
                end
            end else if (inclk) begin
                m_err = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [11:0] c, input logic d);
        color   = c;
        in_done = d;
        inclk   = 1'b1;
        @(posedge clk);
        #1;
        inclk   = 1'b0;
        in_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_q.delete();
        first_acc = -1;
    endtask

    task automatic expect_bytes(input string nm, input int n,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input int didx);
        logic [7:0] bs[3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        chk({nm, "_count"}, log_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("%s_byte%0d", nm, i), {24'd0, log_q[i].b}, {24'd0, bs[i]});
                chk($sformatf("%s_done%0d", nm, i), {31'd0, log_q[i].d}, {31'd0, (i == didx)});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with readclk and inclk active
        rst = 1'b1; readclk = 1'b1; inclk = 1'b1; color = 12'hFFF; in_done = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_outclk", {31'd0, outclk}, 32'd0);
        chk("rst_rdy",    {31'd0, rdy},    32'd0);
        chk("rst_err",    {31'd0, err},    32'd0);
        @(posedge clk); #1;
        rst = 1'b0; inclk = 1'b0; in_done = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy",    {31'd0, rdy},    32'd1);
        chk("post_rst_outclk", {31'd0, outclk}, 32'd0);
        chk("post_rst_out",    {24'd0, out_b},  32'd0);
        idle(1);

        // 2: two colors, three bytes, done on the last
        clear_log();
        push(12'hABC, 1'b0);
        push(12'hDEF, 1'b1);
        idle(4);
        expect_bytes("t2", 3, 8'hAB, 8'hCD, 8'hEF, 2);
        if (log_q.size() > 0)
            chk("t2_latency", log_q[0].cyc - first_acc, 1);
        else
            chk("t2_latency", 32'hFFFF_FFFF, 1);

        // 3: single color padded with the fill nibble
        clear_log();
        push(12'h123, 1'b1);
        idle(4);
        expect_bytes("t3", 2, 8'h12, 8'h35, 8'h00, 1);

        // 4: fill buffer with no reads, overflow drops a color
        readclk = 1'b0;
        clear_log();
        push(12'h111, 1'b0);
        @(negedge clk);
        chk("t4_rdy_cnt3", {31'd0, rdy}, 32'd1);
        push(12'h222, 1'b0);
        @(negedge clk);
        chk("t4_rdy_cnt6", {31'd0, rdy}, 32'd0);
        push(12'h333, 1'b0);
        @(negedge clk);
        chk("t4_err", {31'd0, err}, 32'd1);
        readclk = 1'b1;
        idle(5);
        expect_bytes("t4", 3, 8'h11, 8'h12, 8'h22, -1);

        // 5: read and write in the same cycle at cnt=3
        readclk = 1'b0;
        clear_log();
        push(12'hABC, 1'b0);
        readclk = 1'b1;
        push(12'hDEF, 1'b0);
        idle(4);
        expect_bytes("t5", 3, 8'hAB, 8'hCD, 8'hEF, -1);

        // 6: reset mid-stream, then a fresh stream
        readclk = 1'b1;
        clear_log();
        push(12'h456, 1'b0);
        push(12'h789, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(4);
        expect_bytes("t6_abort", 1, 8'h45, 8'h00, 8'h00, -1);
        clear_log();
        push(12'h0F0, 1'b0);
        push(12'hF0F, 1'b1);
        idle(4);
        expect_bytes("t6_new", 3, 8'h0F, 8'h0F, 8'h0F, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
